// File: rtl/alu_pkg.sv
// Shared definitions for the alu_pipe slice: op encodings, status bit positions, FSM states.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SBC  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_EOR  = 4'd4;
  localparam logic [3:0] OP_ORA  = 4'd5;
  localparam logic [3:0] OP_BIT  = 4'd6;
  localparam logic [3:0] OP_ASL  = 4'd7;
  localparam logic [3:0] OP_LSR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  localparam int unsigned C_BIT = 7;
  localparam int unsigned Z_BIT = 6;
  localparam int unsigned I_BIT = 5;
  localparam int unsigned D_BIT = 4;
  localparam int unsigned B_BIT = 3;
  localparam int unsigned V_BIT = 1;
  localparam int unsigned N_BIT = 0;

  typedef enum logic [0:0] {StIdle, StMulBusy} alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: loads on start, retires one multiplier bit per edge,
// raises done (combinational) on the WIDTH-th edge with the final product on product.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   hi_sum;

  always_comb begin
    hi_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    // Partial sum shifted right one place; lo_q drains the multiplier as it fills with product.
    product = {hi_sum, lo_q[WIDTH-1:1]};
    done    = busy_q && (cnt_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      mcand_q <= a;
      hi_q    <= '0;
      lo_q    <= b;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      {hi_q, lo_q} <= product;
      cnt_q        <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked 6502-style ALU with registered outputs and a multi-cycle MUL.
// Define ALU_DECIMAL_EN to build packed-BCD ADC/SBC when the D flag is set.
module alu_pipe import alu_pkg::*; #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic [7:0]       status_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       status_out
);

  localparam int unsigned Msb = WIDTH - 1;

  alu_state_e state_q, state_d;
  logic accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [3:0] mul_flags_q;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic [7:0]       status_q, status_d;

  logic [WIDTH-1:0] b_eff, alu_res;
  logic [WIDTH:0]   sum;
  logic             cin, c, v, z, n;
  logic [7:0]       alu_status, mul_status;

  logic unused_status;
  assign unused_status = ^{status_in[Z_BIT], status_in[N_BIT]};

  // FSM: state register, next state, outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (mul_start) state_d = StMulBusy;
      StMulBusy: if (mul_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready) && !rst;
    accept    = in_valid && in_ready;
    mul_start = accept && (op == OP_MUL);
  end

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (operand_1),
    .b      (operand_2),
    .done   (mul_done),
    .product(mul_product)
  );

`ifdef ALU_DECIMAL_EN
  logic [WIDTH-1:0] dec_res;
  logic [4:0]       nib;
  logic             nib_c;

  always_comb begin
    dec_res = '0;
    nib     = '0;
    nib_c   = status_in[C_BIT];
    for (int i = 0; i < int'(WIDTH / 4); i++) begin
      if (op == OP_SBC) begin
        nib   = {1'b0, operand_1[4*i +: 4]} + {1'b0, ~operand_2[4*i +: 4]} + {4'b0, nib_c};
        nib_c = nib[4];
        dec_res[4*i +: 4] = nib_c ? nib[3:0] : nib[3:0] - 4'd6;
      end else begin
        nib   = {1'b0, operand_1[4*i +: 4]} + {1'b0, operand_2[4*i +: 4]} + {4'b0, nib_c};
        nib_c = nib > 5'd9;
        dec_res[4*i +: 4] = nib_c ? nib[3:0] + 4'd6 : nib[3:0];
      end
    end
  end
`endif

  always_comb begin
    b_eff   = (op == OP_SBC) ? ~operand_2 : operand_2;
    cin     = (op == OP_ADD) ? 1'b0 : status_in[C_BIT];
    sum     = {1'b0, operand_1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    alu_res = operand_2;
    c       = status_in[C_BIT];
    v       = status_in[V_BIT];
    case (op)
      OP_ADD, OP_ADC, OP_SBC: begin
        alu_res = sum[Msb:0];
        c       = sum[WIDTH];
        v       = (operand_1[Msb] == b_eff[Msb]) && (sum[Msb] != operand_1[Msb]);
      end
      OP_AND, OP_BIT: alu_res = operand_1 & operand_2;
      OP_EOR:         alu_res = operand_1 ^ operand_2;
      OP_ORA:         alu_res = operand_1 | operand_2;
      OP_ASL: begin alu_res = {operand_2[Msb-1:0], 1'b0}; c = operand_2[Msb]; end
      OP_LSR: begin alu_res = {1'b0, operand_2[Msb:1]}; c = operand_2[0]; end
      OP_ROL: begin alu_res = {operand_2[Msb-1:0], status_in[C_BIT]}; c = operand_2[Msb]; end
      OP_ROR: begin alu_res = {status_in[C_BIT], operand_2[Msb:1]}; c = operand_2[0]; end
      default: alu_res = operand_2;
    endcase
    z = (alu_res == '0);
    n = alu_res[Msb];
    if (op == OP_BIT) begin
      n = operand_2[Msb];
      v = operand_2[Msb-1];
    end
`ifdef ALU_DECIMAL_EN
    // N and V stay with the binary sum; only result, C and Z come from the BCD path.
    if ((op == OP_ADC || op == OP_SBC) && status_in[D_BIT]) begin
      alu_res = dec_res;
      c       = nib_c;
      z       = (dec_res == '0);
    end
`endif
    alu_status        = '0;
    alu_status[C_BIT] = c;
    alu_status[Z_BIT] = z;
    alu_status[5:2]   = status_in[5:2];
    alu_status[V_BIT] = v;
    alu_status[N_BIT] = n;

    mul_status        = '0;
    mul_status[C_BIT] = |mul_product[2*WIDTH-1:WIDTH];
    mul_status[Z_BIT] = (mul_product == '0);
    mul_status[5:2]   = mul_flags_q;
    mul_status[N_BIT] = mul_product[Msb];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    status_d    = status_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept && (op != OP_MUL)) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      result_hi_d = '0;
      status_d    = alu_status;
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      result_d    = mul_product[Msb:0];
      result_hi_d = mul_product[2*WIDTH-1:WIDTH];
      status_d    = mul_status;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      status_q    <= '0;
      mul_flags_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      status_q    <= status_d;
      if (mul_start) mul_flags_q <= status_in[5:2];
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign status_out = status_q;

endmodule
